// File: rtl/debounce_bank.sv
// debounce_bank
//   Multi-channel push-button / switch conditioner. Each raw pin passes through
//   a two-flop synchroniser and an optional per-channel inversion, then a
//   per-channel counter that only accepts a new level after it has persisted for
//   STABLE_TICKS consecutive ticks of a shared, free-running prescaler. Each
//   channel gives a clean level plus one-cycle rise/fall strobes.
//
// Ports
//   clk     in   1   system clock
//   rst     in   1   synchronous reset, active-high (dominates all activity)
//   btn     in   CH  raw asynchronous pins
//   out     out  CH  debounced level (after INVERT)
//   rise    out  CH  one-cycle strobe in the cycle out[i] goes 0->1
//   fall    out  CH  one-cycle strobe in the cycle out[i] goes 1->0
//   change  out  1   OR of all rise/fall strobes
`timescale 1ns/1ps

module debounce_bank #(
  parameter int            CH           = 4,
  parameter int            PRESCALE     = 1024,
  parameter int            STABLE_TICKS = 8,
  parameter logic [CH-1:0] INVERT       = '0,
  parameter logic          RST_LEVEL    = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] btn,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          change
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  // Reset value of the sync flops is pre-inverted so that the conditioned level
  // equals RST_LEVEL straight out of reset and no spurious edge is seen.
  localparam logic [CH-1:0] SYNC_RST = {CH{RST_LEVEL}} ^ INVERT;

  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [CH-1:0] out_q, out_d;
  logic [CH-1:0] rise_q, rise_d;
  logic [CH-1:0] fall_q, fall_d;
  logic [CW-1:0] cnt_q [CH];
  logic [CW-1:0] cnt_d [CH];

  logic [CH-1:0] s;
  logic          tick;

  // Synchroniser stage
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
  end

  assign s = sync2_q ^ INVERT;

  // Shared prescaler: tick is high for the single cycle the count sits at PRESCALE-1
  assign tick = (pre_q == PRE_LAST);

  always_comb begin
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  // Per-channel stability counters and acceptance
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < CH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (s[i] == out_q[i]) begin
        // Any agreeing cycle cancels a pending change.
        cnt_d[i] = '0;
      end else if (tick && (cnt_q[i] == CNT_LAST)) begin
        out_d[i]  = s[i];
        cnt_d[i]  = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else if (tick) begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= SYNC_RST;
      sync2_q <= SYNC_RST;
      pre_q   <= '0;
      out_q   <= {CH{RST_LEVEL}};
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pre_q   <= pre_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int i = 0; i < CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign out    = out_q;
  assign rise   = rise_q;
  assign fall   = fall_q;
  assign change = |(rise_q | fall_q);

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
//   Bench for debounce_bank with CH=4, PRESCALE=4, STABLE_TICKS=3,
//   INVERT=4'b1000, RST_LEVEL=0. Each stimulus step pushes the strobe it should
//   cause (with the cycle it was driven) onto a queue; a monitor pops one entry
//   per observed strobe and checks strobe pattern, latency window (11..14
//   edges), strobe width, change, and the tracked output level.
`timescale 1ns/1ps

module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] out;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       change;

  debounce_bank #(
    .CH          (4),
    .PRESCALE    (4),
    .STABLE_TICKS(3),
    .INVERT      (4'b1000),
    .RST_LEVEL   (1'b0)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .out   (out),
    .rise  (rise),
    .fall  (fall),
    .change(change)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    int         c0;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_checks  = 0;
  int         n_errors  = 0;
  int         cyc       = 0;
  int         rel       = 0;
  int         last_lat  = -1;
  bit         mon_en    = 1'b0;
  logic [3:0] exp_out   = 4'b0000;
  logic [3:0] prev_rise = 4'b0000;
  logic [3:0] prev_fall = 4'b0000;
  string      cur_test  = "T1";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples 1ns after each active edge.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (rst) exp_out = 4'b0000;
      if ((rise | fall) != 4'b0000) begin
        if (exp_q.size() == 0) begin
          check({cur_test, "_unexpected_strobe"}, 32'({rise, fall}), 32'h0);
        end else begin
          mon_e    = exp_q.pop_front();
          last_lat = cyc - mon_e.c0;
          check({cur_test, "_rise"}, 32'(rise), 32'(mon_e.rise));
          check({cur_test, "_fall"}, 32'(fall), 32'(mon_e.fall));
          check($sformatf("%s_latency_%0d_in_11_14", cur_test, last_lat),
                32'((last_lat >= 11) && (last_lat <= 14)), 32'd1);
          check({cur_test, "_change_on_strobe"}, 32'(change), 32'd1);
          exp_out = (exp_out | mon_e.rise) & ~mon_e.fall;
        end
      end else begin
        check({cur_test, "_change_idle"}, 32'(change), 32'd0);
      end
      check({cur_test, "_rise_and_fall"}, 32'(rise & fall), 32'h0);
      check({cur_test, "_rise_width"}, 32'(rise & prev_rise), 32'h0);
      check({cur_test, "_fall_width"}, 32'(fall & prev_fall), 32'h0);
      check({cur_test, "_out_level"}, 32'(out), 32'(exp_out));
      prev_rise = rise;
      prev_fall = fall;
    end
  end

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_strobe(input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.c0   = cyc;
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check({cur_test, "_timeout_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    // Quiet period so any extra strobe shows up as unexpected.
    tick_n(6);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int min_lat;
    int max_lat;

    // T1: reset with the active-low pin idle-high
    rst = 1'b1;
    btn = 4'b1000;
    @(posedge clk);
    mon_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("T1_out_in_reset", 32'(out), 32'h0);
      check("T1_rise_in_reset", 32'(rise), 32'h0);
      check("T1_fall_in_reset", 32'(fall), 32'h0);
      check("T1_change_in_reset", 32'(change), 32'h0);
    end
    rst = 1'b0;
    rel = cyc;
    tick_n(30);
    check("T1_out_after_hold", 32'(out), 32'h0);

    // T2: clean press/release of btn[0] at every prescaler phase
    cur_test = "T2";
    min_lat  = 99;
    max_lat  = 0;
    for (int ph = 0; ph < 4; ph++) begin
      while (((cyc - rel) % 4) != ph) @(negedge clk);
      btn[0] = 1'b1;
      expect_strobe(4'b0001, 4'b0000);
      drain(30);
      if (last_lat < min_lat) min_lat = last_lat;
      if (last_lat > max_lat) max_lat = last_lat;
      btn[0] = 1'b0;
      expect_strobe(4'b0000, 4'b0001);
      drain(30);
    end
    check("T2_min_latency", 32'(min_lat), 32'd11);
    check("T2_max_latency", 32'(max_lat), 32'd14);

    // T3: btn[1] bounces every 3 cycles, then holds high
    cur_test = "T3";
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      btn[1] = ((i / 3) % 2 == 0);
    end
    @(negedge clk);
    btn[1] = 1'b1;
    expect_strobe(4'b0010, 4'b0000);
    drain(30);
    check("T3_out_after", 32'(out), 32'h2);

    // T4: active-low channel press then release
    cur_test = "T4";
    btn[3] = 1'b0;
    expect_strobe(4'b1000, 4'b0000);
    drain(30);
    btn[3] = 1'b1;
    expect_strobe(4'b0000, 4'b1000);
    drain(30);

    // T5: three channels pressed on the same edge
    cur_test = "T5";
    btn[1] = 1'b0;
    expect_strobe(4'b0000, 4'b0010);
    drain(30);
    btn[2:0] = 3'b111;
    expect_strobe(4'b0111, 4'b0000);
    drain(30);
    check("T5_out_all", 32'(out), 32'h7);
    btn[2:0] = 3'b000;
    expect_strobe(4'b0000, 4'b0111);
    drain(30);

    // T6: reset lands in the middle of a pending press
    cur_test = "T6";
    btn[0] = 1'b1;
    tick_n(6);
    rst = 1'b1;
    tick_n(2);
    check("T6_out_in_reset", 32'(out), 32'h0);
    rst = 1'b0;
    expect_strobe(4'b0001, 4'b0000);
    drain(30);
    check("T6_out_after", 32'(out), 32'h1);

    check("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
